// File: rtl/sat_add_arbiter.sv
// sat_add_arbiter: round-robin arbiter sharing one 4-bit saturating signed adder among NREQ requesters.
// Define SAT_ADD_ARB_OVF_CNT_EN to build the saturating overflow event counter driving ovf_count.
module sat_add_arbiter #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [4*NREQ-1:0]   req_a,
   input  logic [4*NREQ-1:0]   req_b,
   input  logic [NREQ-1:0]     req_cin,
   output logic [NREQ-1:0]     req_ready,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [3:0]          rsp_sum,
   output logic                rsp_cout,
   output logic                rsp_ovf,
   output logic [7:0]          ovf_count
);
   typedef enum logic [1:0] {ARB, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic [IDW-1:0] ptr, gnt_idx, gnt_off, op_id;
   logic [IDW:0] gnt_sum;
   logic [NREQ-1:0] rot;
   logic [3:0] a_arr [NREQ];
   logic [3:0] b_arr [NREQ];
   logic [3:0] op_a, op_b, sat_sum;
   logic [4:0] full;
   logic op_cin, gnt_found, grant, c3, c4, ovf;
   // Rotate requests so bit 0 is the requester at ptr; the lowest set bit is the winner.
   always_comb begin
      rot = NREQ'({req_valid, req_valid} >> ptr);
      gnt_off = '0;
      for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) gnt_off = IDW'(k);
      gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
      gnt_idx = (gnt_sum >= (IDW+1)'(NREQ)) ? IDW'(gnt_sum - (IDW+1)'(NREQ)) : gnt_sum[IDW-1:0];
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = req_a[4*i +: 4];
         b_arr[i] = req_b[4*i +: 4];
      end
   end
   assign gnt_found = |req_valid;
   assign grant     = rst_n && state == ARB && gnt_found;
   assign req_ready = grant ? {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx : '0;
   assign rsp_valid = rst_n && state == RESP;
   assign full    = {1'b0, op_a} + {1'b0, op_b} + {4'b0, op_cin};
   assign c4      = full[4];
   assign c3      = full[3] ^ op_a[3] ^ op_b[3];
   assign ovf     = c3 ^ c4;
   assign sat_sum = ovf ? {op_a[3], {3{~op_a[3]}}} : full[3:0];
   always_comb begin
      state_nx = (state == ARB)  ? (gnt_found ? EXEC : ARB) :
                 (state == EXEC) ? RESP :
                 (rsp_ready ? ARB : RESP);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ARB;
      else        state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr      <= '0;
         op_id    <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_cin   <= 1'b0;
         rsp_id   <= '0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
         rsp_ovf  <= 1'b0;
      end else begin
         if (grant) begin
            op_id  <= gnt_idx;
            op_a   <= a_arr[gnt_idx];
            op_b   <= b_arr[gnt_idx];
            op_cin <= req_cin[gnt_idx];
            ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
         if (state == EXEC) begin
            rsp_id   <= op_id;
            rsp_sum  <= sat_sum;
            rsp_cout <= c4;
            rsp_ovf  <= ovf;
         end
      end
   end
`ifdef SAT_ADD_ARB_OVF_CNT_EN
   logic [7:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n) cnt <= '0;
      else if (rsp_valid && rsp_ready && rsp_ovf && cnt != 8'hFF) cnt <= cnt + 8'd1;
   end
   assign ovf_count = cnt;
`else
   assign ovf_count = 8'h00;
`endif
endmodule

// File: tb/tb_sat_add_arbiter.sv
// tb_sat_add_arbiter: directed stimulus with a per-cycle arithmetic reference model and literal checks.
module tb_sat_add_arbiter;
   localparam int NREQ = 4;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [NREQ-1:0] req_valid = '0, req_cin = '0, req_ready;
   logic [4*NREQ-1:0] req_a = '0, req_b = '0;
   logic rsp_valid, rsp_ready = 1'b1, rsp_cout, rsp_ovf;
   logic [1:0] rsp_id;
   logic [3:0] rsp_sum;
   logic [7:0] ovf_count;
   int checks = 0, errors = 0, cyc = 0;
   bit started = 0;
   int m_phase = 0, m_ptr = 0, m_g, m_cnt = 0, sa, sb, s, c_g, c_k;
   logic [3:0] m_a, m_b, m_sum = '0;
   logic m_cin, m_cout = 1'b0, m_ovf = 1'b0;
   logic [1:0] m_id = '0;
   int g_idx[$], g_cyc[$];
   int nv, n0;
   sat_add_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_cin(req_cin), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
      .ovf_count(ovf_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction
   // Reference model: advances one clock at a time from the sampled inputs.
   initial forever begin
      @(posedge clk);
      cyc++;
      started = 1;
      if (!rst_n) begin
         m_phase = 0; m_ptr = 0; m_cnt = 0;
         m_id = '0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else if (m_phase == 0) begin
         m_g = exp_grant(req_valid, m_ptr);
         if (m_g >= 0) begin
            m_a = req_a[4*m_g +: 4];
            m_b = req_b[4*m_g +: 4];
            m_cin = req_cin[m_g];
            m_ptr = (m_g + 1) % NREQ;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         sa = $signed(m_a);
         sb = $signed(m_b);
         s = sa + sb + int'(m_cin);
         m_ovf = (s > 7) || (s < -8);
         m_sum = (s > 7) ? 4'b0111 : (s < -8) ? 4'b1000 : 4'(s);
         m_cout = (((int'(m_a) + int'(m_b) + int'(m_cin)) >> 4) & 1) != 0;
         m_id = 2'(m_g);
         m_phase = 2;
      end else if (rsp_ready) begin
         if (m_ovf && m_cnt < 255) m_cnt++;
         m_phase = 0;
      end
   end
   initial forever begin
      @(negedge clk);
      if (started) begin
         c_g = exp_grant(req_valid, m_ptr);
         chk("req_ready", req_ready, (rst_n && m_phase == 0 && c_g >= 0) ? (1 << c_g) : 0);
         chk("rsp_valid", rsp_valid, rst_n && m_phase == 2);
         chk("rsp_id", rsp_id, m_id);
         chk("rsp_sum", rsp_sum, m_sum);
         chk("rsp_cout", rsp_cout, m_cout);
         chk("rsp_ovf", rsp_ovf, m_ovf);
`ifdef SAT_ADD_ARB_OVF_CNT_EN
         chk("ovf_count", ovf_count, m_cnt);
`else
         chk("ovf_count", ovf_count, 0);
`endif
         if (req_ready != 0) begin
            c_k = 0;
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) c_k = k;
            g_idx.push_back(c_k);
            g_cyc.push_back(cyc);
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic c);
      req_a[4*i +: 4] = a;
      req_b[4*i +: 4] = b;
      req_cin[i] = c;
   endtask
   task automatic wait_rsp(input string name);
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk(name, rsp_valid, 1);
   endtask
   task automatic op(input int i, input logic [3:0] a, input logic [3:0] b, input logic c);
      tick();
      set_op(i, a, b, c);
      req_valid = NREQ'(1 << i);
      tick();
      req_valid = '0;
      wait_rsp("rsp_timeout");
   endtask
   initial begin
      req_valid = '1;
      repeat (3) begin
         @(negedge clk);
         chk("reset_req_ready", req_ready, 0);
         chk("reset_rsp_valid", rsp_valid, 0);
      end
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_rsp_sum", rsp_sum, 0);
      chk("reset_rsp_cout", rsp_cout, 0);
      chk("reset_rsp_ovf", rsp_ovf, 0);
      chk("reset_ovf_count", ovf_count, 0);
      tick();
      rst_n = 1'b1;
      req_valid = '0;
      op(2, 4'd3, 4'd2, 1'b1);
      chk("single_id", rsp_id, 2);
      chk("single_sum", rsp_sum, 4'b0110);
      chk("single_cout", rsp_cout, 0);
      chk("single_ovf", rsp_ovf, 0);
      op(1, 4'd7, 4'd1, 1'b0);
      chk("pos_sat_sum", rsp_sum, 4'b0111);
      chk("pos_sat_ovf", rsp_ovf, 1);
      chk("pos_sat_cout", rsp_cout, 0);
      op(0, 4'b1000, 4'b1111, 1'b0);
      chk("neg_sat_sum", rsp_sum, 4'b1000);
      chk("neg_sat_ovf", rsp_ovf, 1);
      chk("neg_sat_cout", rsp_cout, 1);
      op(3, 4'd1, 4'd1, 1'b0);
      chk("ptr_wrap_sum", rsp_sum, 4'd2);
      // Round robin under full contention, ptr back at 0.
      tick();
      g_idx.delete();
      g_cyc.delete();
      set_op(0, 4'd2, 4'd3, 1'b0);
      set_op(1, 4'b1100, 4'b1110, 1'b1);
      set_op(2, 4'd6, 4'd6, 1'b0);
      set_op(3, 4'b1001, 4'd1, 1'b1);
      req_valid = '1;
      repeat (13) tick();
      req_valid = '0;
      repeat (6) tick();
      chk("rr_count", g_idx.size(), 5);
      if (g_idx.size() >= 5) begin
         chk("rr_order0", g_idx[0], 0);
         chk("rr_order1", g_idx[1], 1);
         chk("rr_order2", g_idx[2], 2);
         chk("rr_order3", g_idx[3], 3);
         chk("rr_order4", g_idx[4], 0);
         for (int k = 1; k < 5; k++) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 3);
      end
      // Backpressure: response must hold and no new grant while stalled.
      set_op(1, 4'd5, 4'd4, 1'b0);
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      tick();
      wait_rsp("bp_rsp_timeout");
      repeat (5) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_id", rsp_id, 1);
         chk("bp_sum", rsp_sum, 4'b0111);
         chk("bp_ovf", rsp_ovf, 1);
         chk("bp_cout", rsp_cout, 0);
         chk("bp_no_grant", req_ready, 0);
         @(negedge clk);
      end
      tick();
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (2) tick();
      // Reset during EXEC: no response, ptr returns to 0.
      set_op(2, 4'd1, 4'd1, 1'b0);
      req_valid = 4'b0100;
      tick();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      nv = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) nv++;
      end
      chk("no_rsp_after_reset", nv, 0);
      n0 = g_idx.size();
      tick();
      set_op(0, 4'd1, 4'd1, 1'b0);
      set_op(3, 4'd2, 4'd2, 1'b0);
      req_valid = 4'b1001;
      tick();
      req_valid = '0;
      wait_rsp("post_reset_rsp_timeout");
      chk("post_reset_grants", g_idx.size(), n0 + 1);
      if (g_idx.size() > n0) chk("post_reset_grant", g_idx[n0], 0);
      chk("post_reset_id", rsp_id, 0);
      chk("post_reset_sum", rsp_sum, 4'd2);
      // 300 overflowing operations from requester 0.
      tick();
      set_op(0, 4'd7, 4'd7, 1'b0);
      req_valid = 4'b0001;
      repeat (902) tick();
      req_valid = '0;
      repeat (4) tick();
      @(negedge clk);
`ifdef SAT_ADD_ARB_OVF_CNT_EN
      chk("ovf_count_sat", ovf_count, 8'hFF);
`else
      chk("ovf_count_off", ovf_count, 8'h00);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sat_add_arbiter.md
# sat_add_arbiter

Round-robin arbiter and sequencer that shares one 4-bit two's-complement saturating adder among NREQ requesters. Each transaction runs through a fixed three-phase sequence: grant, execute, respond. Operands are latched at grant, and the saturated sum, carry-out and overflow flag are returned on a single response channel tagged with the requester ID. The block sits between the lab's operand sources (switch/keypad front-ends) and the display path.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of rsp_id; derived, never overridden.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_a  in  4*NREQ  operand A of requester i in bits [4i+3:4i], signed.
- req_b  in  4*NREQ  operand B of requester i, same packing, signed.
- req_cin  in  NREQ  carry-in per requester.
- req_ready  out  NREQ  one-hot grant; handshake occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the granted requester.
- rsp_sum  out  4  saturated signed sum.
- rsp_cout  out  1  raw carry out of bit 3.
- rsp_ovf  out  1  signed overflow occurred and saturation was applied.
- ovf_count  out  8  overflow event counter (see Configuration).

## Operation
- FSM states: ARB, EXEC, RESP. Reset state is ARB.
- **ARB**
  - req_ready is combinational: it is the one-hot bit of the first set req_valid bit, searching upward from ptr with wrap-around.
  - req_ready is all-zero when req_valid is 0 or the state is not ARB.
  - On grant to requester g: latch a, b, cin and g; set ptr <= (g+1) mod NREQ; go to EXEC.
  - With no request, stay in ARB and leave ptr unchanged.
- **EXEC**
  - Compute s = a + b + cin.
  - Carries: c3 is the carry into bit 3; c4 is the carry out of bit 3.
  - ovf = c3 ^ c4.
  - rsp_sum = ovf ? {a[3], ~a[3], ~a[3], ~a[3]} : s[3:0]. This gives 4'b0111 on positive overflow and 4'b1000 on negative overflow.
  - rsp_cout = c4, unaffected by saturation.
  - Register all results; go to RESP.
- **RESP**
  - rsp_valid = 1. All rsp_* outputs are held stable until rsp_ready is high.
  - On rsp_ready: go to ARB. The next grant can occur in the following cycle, not the same cycle.
- **Requester rules**
  - A requester may drop req_valid at any time before its grant.
  - Operands only need to be valid in the grant cycle.
  - Changes to req_valid during EXEC or RESP have no effect.
- **ptr**: IDW bits, reset value 0.
- **Reset mid-operation**: the in-flight transaction is discarded with no response; FSM returns to ARB and ptr to 0.
- **Reset values**: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, ovf_count=0.

## Timing
- Grant in cycle T (handshake edge at the end of T).
- EXEC in T+1.
- rsp_valid rises in T+2.
- With rsp_ready held high, the response handshake is at T+2, ARB is in T+3, and the next grant is possible in T+3.
- Peak throughput is one operation per 3 cycles.
- Each cycle rsp_ready is low adds one cycle of stall.
- Fairness: under continuous contention from all requesters, each requester is granted exactly once in every NREQ transactions.

## Configuration
- Macro: SAT_ADD_ARB_OVF_CNT_EN.
- **Defined**
  - ovf_count increments by 1 on each response handshake with rsp_ovf=1.
  - It saturates at 8'hFF and never wraps.
  - It is cleared only by reset.
- **Undefined**
  - The counter logic is not built; ovf_count is tied to 8'h00.
  - All other behaviour is identical.

## Test plan
- **Reset**: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=0 and rsp_valid=0 throughout; all outputs 0.
- **Single request, no saturation**: requester 2 only, a=3, b=2, cin=1 -> grant in T; in T+2, rsp_id=2, rsp_sum=4'b0110, rsp_cout=0, rsp_ovf=0.
- **Saturation, both directions**:
  - a=7, b=1, cin=0 -> rsp_sum=4'b0111, rsp_ovf=1, rsp_cout=0.
  - a=-8, b=-1, cin=0 -> rsp_sum=4'b1000, rsp_ovf=1, rsp_cout=1.
- **Round-robin**: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0, with consecutive grants 3 cycles apart.
- **Backpressure and mid-op reset**:
  - rsp_ready=0 for 5 cycles -> rsp_* stable and no new grant issued.
  - Pulse rst_n low during EXEC -> no response is produced, and the next grant goes to requester 0.
- **Overflow counter** (macro defined): 300 overflowing operations -> ovf_count=8'hFF. Without the macro -> ovf_count stays 0.
